// File: rtl/nco_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nco_pkg
// Description : Shared definitions for the multi-channel NCO clock generator.
//               Holds the default sizing constants, the channel index type and
//               a helper that converts a target frequency into a phase
//               increment.
// Revision    : 1.0 - initial release
// ============================================================================
package nco_pkg;

    // Default sizing for a typical instance.
    localparam int c_default_acc_w       = 16;
    localparam int c_default_lock_cycles = 16;

    // Wide enough for the largest supported channel count (16).
    typedef logic [3:0] ch_idx_t;

    // Increment that produces f_out ticks per second from an f_clk clock with
    // an acc_w-bit accumulator: inc = f_out * 2^acc_w / f_clk (truncated).
    // Intended for elaboration-time constants and testbench setup only.
    function automatic longint unsigned freq_to_inc(input longint unsigned f_out,
                                                    input longint unsigned f_clk,
                                                    input int              acc_w);
        return (f_out << acc_w) / f_clk;
    endfunction

endpackage : nco_pkg
`default_nettype wire

// File: rtl/nco_clock_gen_channel.sv
`default_nettype none
// ============================================================================
// Module      : nco_channel
// Description : One NCO channel. A phase accumulator advanced by a
//               programmable increment every clock; the carry out is the tick
//               and the accumulator MSB is the square wave. A lock counter
//               reports when the increment has been stable and nonzero for
//               LOCK_CYCLES clocks.
// Ports       : clkin   - clock
//               rst     - synchronous active-high reset
//               sel_we  - write strobe already qualified for this channel
//               cfg_inc - increment to load on sel_we
//               sync    - shared accumulator clear (phase alignment)
//               tick    - one-cycle pulse on accumulator carry
//               clk_sq  - accumulator MSB
//               locked  - increment stable and nonzero for LOCK_CYCLES
// Revision    : 1.0 - initial release
// ============================================================================
module nco_channel
    import nco_pkg::*;
#(
    parameter int ACC_W       = c_default_acc_w,
    parameter int LOCK_CYCLES = c_default_lock_cycles
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             sel_we,
    input  logic [ACC_W-1:0] cfg_inc,
    input  logic             sync,
    output logic             tick,
    output logic             clk_sq,
    output logic             locked
);

    localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] c_lock_max = CNT_W'(LOCK_CYCLES);

    logic [ACC_W-1:0] r_inc;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_lock_cnt;

    logic [ACC_W:0]   w_sum;
    logic [CNT_W-1:0] w_cnt_nxt;

    // Carry lands in the extra top bit; the low bits wrap modulo 2^ACC_W.
    assign w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
    assign w_cnt_nxt = r_lock_cnt + CNT_W'(1);

    // Phase accumulator and outputs. The sum uses the increment held before
    // any write at this edge, so a new increment first accumulates one edge
    // later. sync discards this edge's addition entirely.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_acc  <= '0;
            tick   <= 1'b0;
            clk_sq <= 1'b0;
        end else if (sync) begin
            r_acc  <= '0;
            tick   <= 1'b0;
            clk_sq <= 1'b0;
        end else begin
            r_acc  <= w_sum[ACC_W-1:0];
            tick   <= w_sum[ACC_W];
            clk_sq <= w_sum[ACC_W-1];
        end
    end

    // Increment register and lock tracking. A write restarts the lock count;
    // a zero increment never counts so the channel can never report lock
    // while stopped.
    always_ff @(posedge clkin) begin
        if (rst) begin
            r_inc      <= '0;
            r_lock_cnt <= '0;
            locked     <= 1'b0;
        end else if (sel_we) begin
            r_inc      <= cfg_inc;
            r_lock_cnt <= '0;
            locked     <= 1'b0;
        end else if ((r_inc != '0) && (r_lock_cnt < c_lock_max)) begin
            r_lock_cnt <= w_cnt_nxt;
            locked     <= (w_cnt_nxt == c_lock_max) | locked;
        end
    end

endmodule : nco_channel
`default_nettype wire

// File: rtl/nco_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : nco_clock_gen
// Description : Multi-channel numerically-controlled oscillator producing
//               fractional-rate clock enables and square waves on the single
//               board clock. Decodes the shared configuration write port and
//               instantiates one nco_channel per channel.
// Ports       : clkin   - sole clock
//               rst     - synchronous active-high reset
//               cfg_we  - increment write strobe
//               cfg_ch  - channel index for the write (out of range ignored)
//               cfg_inc - new phase increment
//               sync    - zero all accumulators together
//               tick    - per-channel carry pulse
//               clk_sq  - per-channel accumulator MSB
//               locked  - per-channel lock indication
// Revision    : 1.0 - initial release
// ============================================================================
module nco_clock_gen
    import nco_pkg::*;
#(
    parameter  int NUM_CH      = 2,
    parameter  int ACC_W       = c_default_acc_w,
    parameter  int LOCK_CYCLES = c_default_lock_cycles,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [ACC_W-1:0]  cfg_inc,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] clk_sq,
    output logic [NUM_CH-1:0] locked
);

    logic [NUM_CH-1:0] w_sel_we;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            // An index at or beyond NUM_CH matches no channel, so such a
            // write has no effect anywhere.
            assign w_sel_we[i] = cfg_we && (ch_idx_t'(cfg_ch) == ch_idx_t'(i));

            nco_channel #(
                .ACC_W       (ACC_W),
                .LOCK_CYCLES (LOCK_CYCLES)
            ) u_channel (
                .clkin   (clkin),
                .rst     (rst),
                .sel_we  (w_sel_we[i]),
                .cfg_inc (cfg_inc),
                .sync    (sync),
                .tick    (tick[i]),
                .clk_sq  (clk_sq[i]),
                .locked  (locked[i])
            );
        end
    endgenerate

endmodule : nco_clock_gen
`default_nettype wire

// File: tb/tb_nco_clock_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nco_clock_gen
// Description : Self-checking bench for nco_clock_gen. Directed scenarios
//               followed by randomized traffic, compared every cycle against
//               an arithmetic reference model of the accumulators and of the
//               time elapsed since each channel's last write.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_clock_gen;
    import nco_pkg::*;

    localparam int NUM_CH      = 3;
    localparam int ACC_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int MOD         = 1 << ACC_W;

    logic              clkin = 1'b0;
    logic              rst;
    logic              cfg_we;
    logic [1:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic              sync;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] clk_sq;
    logic [NUM_CH-1:0] locked;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integers.
    int m_inc     [NUM_CH];
    int m_acc     [NUM_CH];
    int m_tick    [NUM_CH];
    int m_sq      [NUM_CH];
    int m_wr_edge [NUM_CH];
    int edge_cnt = 0;

    nco_clock_gen #(
        .NUM_CH      (NUM_CH),
        .ACC_W       (ACC_W),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clkin   (clkin),
        .rst     (rst),
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_inc (cfg_inc),
        .sync    (sync),
        .tick    (tick),
        .clk_sq  (clk_sq),
        .locked  (locked)
    );

    always #5 clkin = ~clkin;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model by one edge using the currently driven inputs.
    task automatic model_edge();
        int s;
        edge_cnt++;
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                m_inc[c] = 0; m_acc[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
            end else begin
                if (sync) begin
                    m_acc[c] = 0; m_tick[c] = 0; m_sq[c] = 0;
                end else begin
                    s         = m_acc[c] + m_inc[c];
                    m_tick[c] = (s >= MOD) ? 1 : 0;
                    m_acc[c]  = s % MOD;
                    m_sq[c]   = (m_acc[c] >= MOD / 2) ? 1 : 0;
                end
                // The write takes effect after this edge's addition.
                if (cfg_we && (int'(cfg_ch) == c)) begin
                    m_inc[c]     = int'(cfg_inc);
                    m_wr_edge[c] = edge_cnt;
                end
            end
        end
    endtask

    // One clock: model update on the edge, DUT compared 1 time unit later.
    task automatic step();
        logic [NUM_CH-1:0] e_tick, e_sq, e_lock;
        @(posedge clkin);
        model_edge();
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            e_tick[c] = (m_tick[c] != 0);
            e_sq[c]   = (m_sq[c] != 0);
            e_lock[c] = (m_inc[c] != 0) && ((edge_cnt - m_wr_edge[c]) >= LOCK_CYCLES);
        end
        check_eq("model_tick",   32'(tick),   32'(e_tick));
        check_eq("model_clk_sq", 32'(clk_sq), 32'(e_sq));
        check_eq("model_locked", 32'(locked), 32'(e_lock));
    endtask

    task automatic cycle(input logic we, input logic [1:0] ch, input logic [ACC_W-1:0] inc,
                         input logic sy, input logic r);
        cfg_we = we; cfg_ch = ch; cfg_inc = inc; sync = sy; rst = r;
        step();
        cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; sync = 1'b0; rst = 1'b0;
    endtask

    initial begin
        bit exp_sq   [8];
        bit exp_tick [8];
        logic [ACC_W-1:0] inc_quarter;
        exp_sq   = '{0, 1, 1, 0, 0, 1, 1, 0};
        exp_tick = '{0, 0, 0, 1, 0, 0, 0, 1};
        inc_quarter = ACC_W'(freq_to_inc(25, 100, ACC_W));   // 64: quarter rate

        for (int c = 0; c < NUM_CH; c++) begin
            m_inc[c] = 0; m_acc[c] = 0; m_tick[c] = 0; m_sq[c] = 0; m_wr_edge[c] = 0;
        end
        cfg_we = 1'b0; cfg_ch = '0; cfg_inc = '0; sync = 1'b0; rst = 1'b1;

        // Reset state.
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 1);
        check_eq("rst_tick",   32'(tick),   32'd0);
        check_eq("rst_clk_sq", 32'(clk_sq), 32'd0);
        check_eq("rst_locked", 32'(locked), 32'd0);

        // Quarter-rate channel: acc 64,128,192,0 -> 50% square, tick every 4th.
        cycle(1, 0, inc_quarter, 0, 0);
        for (int k = 0; k < 8; k++) begin
            cycle(0, 0, 0, 0, 0);
            check_eq($sformatf("quarter_sq_%0d", k),   32'(clk_sq[0]), 32'(exp_sq[k]));
            check_eq($sformatf("quarter_tick_%0d", k), 32'(tick[0]),   32'(exp_tick[k]));
        end

        // Lock timing: write at N, rewrite at N+10, lock after N+26.
        cycle(1, 1, 8'd5, 0, 0);
        for (int k = 1; k <= 9; k++) cycle(0, 0, 0, 0, 0);
        check_eq("lock_before_rewrite", 32'(locked[1]), 32'd0);
        cycle(1, 1, 8'd5, 0, 0);
        for (int k = 11; k <= 25; k++) cycle(0, 0, 0, 0, 0);
        check_eq("lock_at_n25", 32'(locked[1]), 32'd0);
        cycle(0, 0, 0, 0, 0);
        check_eq("lock_at_n26", 32'(locked[1]), 32'd1);

        // Zero increment never locks; out-of-range index is ignored.
        cycle(1, 2, 8'd0, 0, 0);
        cycle(1, 3, 8'd77, 0, 0);
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, 0, 0);
        check_eq("zero_inc_unlocked", 32'(locked[2]), 32'd0);
        check_eq("oob_keeps_lock",    32'(locked[1:0]), 32'd3);

        // Sync: accumulators and ticks clear together, lock is retained.
        cycle(1, 2, 8'd37, 0, 0);
        for (int k = 0; k < 5; k++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0);
        check_eq("sync_tick",   32'(tick),   32'd0);
        check_eq("sync_clk_sq", 32'(clk_sq), 32'd0);
        check_eq("sync_locked", 32'(locked[1:0]), 32'd3);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic              we, sy, r;
            logic [1:0]        ch;
            logic [ACC_W-1:0]  inc;
            we  = ($urandom_range(0, 7) == 0);
            ch  = 2'($urandom_range(0, 3));
            inc = ($urandom_range(0, 5) == 0) ? '0 : ACC_W'($urandom_range(0, MOD - 1));
            sy  = ($urandom_range(0, 39) == 0);
            r   = ($urandom_range(0, 499) == 0);
            cycle(we, ch, inc, sy, r);
        end

        // Mid-run reset: everything clears and stays stopped.
        cycle(1, 0, 8'd200, 0, 0);
        for (int k = 0; k < 20; k++) cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1);
        check_eq("midrst_tick",   32'(tick),   32'd0);
        check_eq("midrst_clk_sq", 32'(clk_sq), 32'd0);
        check_eq("midrst_locked", 32'(locked), 32'd0);
        for (int k = 0; k < 30; k++) cycle(0, 0, 0, 0, 0);
        check_eq("stopped_tick",   32'(tick),   32'd0);
        check_eq("stopped_locked", 32'(locked), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_nco_clock_gen
`default_nettype wire

// File: doc/nco_clock_gen.md
# nco_clock_gen

Multi-channel numerically-controlled oscillator. It derives fractional-rate clock enables and square waves from the board clock using per-channel phase accumulators. Increments are programmable at run time, and each channel reports lock once its setting has been stable. It feeds the TTL serial, ESC/PWM and timer logic as clock enables, which keeps the whole design on a single clock domain.

## Interface
Parameters:
- NUM_CH, 2: number of independent channels (1..16).
- ACC_W, 16: accumulator and increment width in bits (8..32).
- LOCK_CYCLES, 16: stable cycles required before `locked` asserts (≥1).

Ports:
- clkin  in  1  sole clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for one channel's increment.
- cfg_ch  in  max(1,$clog2(NUM_CH))  channel index for the write.
- cfg_inc  in  ACC_W  new phase increment.
- sync  in  1  zeroes all accumulators together (phase alignment).
- tick  out  NUM_CH  one-cycle pulse per channel on accumulator carry.
- clk_sq  out  NUM_CH  accumulator MSB per channel (square wave).
- locked  out  NUM_CH  channel increment stable and nonzero for LOCK_CYCLES.

## Operation
- Per channel, registers are `inc`, `acc`, `lock_cnt`, `tick`, `clk_sq` and `locked`.
- Each edge: {carry, acc} <= acc + inc (ACC_W+1-bit sum). Overflow wraps modulo 2^ACC_W; carry is never saturated.
- tick <= carry. clk_sq <= MSB of the new acc.
- Output rate: f_tick = f_clkin·inc/2^ACC_W. inc=0 stops the channel: tick stays 0 and clk_sq holds its value.
- Write (cfg_we=1, cfg_ch<NUM_CH): inc[cfg_ch] <= cfg_inc. acc is not cleared, so the phase stays continuous.
- A write also sets lock_cnt <= 0 and locked <= 0 for that channel.
- A write with cfg_ch ≥ NUM_CH is ignored with no side effects.
- Lock counting: when there is no write, inc≠0 and lock_cnt<LOCK_CYCLES, lock_cnt increments. locked <= (lock_cnt+1 == LOCK_CYCLES) or locked.
- With inc=0, lock_cnt and locked remain 0.
- sync=1: all acc <= 0 and all tick <= 0 at that edge. The additions for that edge are discarded. inc, lock_cnt and locked are unaffected.
- sync together with cfg_we: both take effect. The accumulators zero, and the written channel's inc and lock state update as for a write.
- Reset (including mid-operation): inc, acc, lock_cnt, tick, clk_sq and locked all return to 0.

## Timing
- All outputs are registered. Reset value of tick, clk_sq and locked is 0.
- Write sampled at edge N: the first accumulation using the new inc happens at edge N+1.
- locked falls at edge N and rises at edge N+LOCK_CYCLES (N+1..N+LOCK_CYCLES count).
- tick and clk_sq change at the same edge as the acc update, with zero added latency versus the carry.
- sync at edge S: acc is 0 after S. The first nonzero acc appears after S+1.
- Channels are fully independent except for the shared sync and write port.

## Structure
- Shared package nco_pkg:
  - default ACC_W and LOCK_CYCLES localparams;
  - ch_idx_t typedef;
  - function freq_to_inc(f_out, f_clk, ACC_W), used only for bench and elaboration constants.
- One sub-module, nco_channel: holds a channel's inc/acc/lock registers plus the write-select input, shared sync and rst.
- The top level decodes cfg_ch and instantiates NUM_CH copies in a generate loop.

## Test plan
- ACC_W=4; write inc=4 to ch0 -> acc 4,8,12,0; tick high every 4th cycle; clk_sq pattern 0,1,1,0 repeating (50% duty).
- ACC_W=4; inc=3 -> exactly 3 ticks per 16 cycles, at acc wrap to values 2, 1 and 0.
- Write inc=5 at edge N with LOCK_CYCLES=16 -> locked=0 after N, 1 after N+16. A rewrite at N+10 restarts the count, so locked rises after N+26. Writing inc=0 keeps locked=0 forever.
- Two channels running different incs, then sync pulse -> both acc=0 and tick=0 that cycle; afterwards the channels are phase-aligned and continue at their own rates.
- cfg_ch=NUM_CH with cfg_we=1 -> no inc, lock or acc changes on any channel.
- rst asserted mid-run for 1 cycle -> all outputs 0 next cycle; channels stay stopped until rewritten.
